// File: rtl/lifo_pkg.sv
// -----------------------------------------------------------------------------
// lifo_pkg
// Shared definitions for the LIFO reader-side drain controller:
//   DATA_W  - width of one stack entry
//   DEPTH   - stack capacity
//   CNT_W   - width of drain counts (2**CNT_W must exceed DEPTH)
//   state_e - drain controller state encoding
// -----------------------------------------------------------------------------
package lifo_pkg;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 5;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/lifo_out_skid.sv
// -----------------------------------------------------------------------------
// lifo_out_skid
// Two-entry output buffer between the LIFO capture point and the downstream
// valid/ready interface. The head word and its valid flag are registered.
// Push and pop in the same cycle are legal.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   push        - write push_data into the buffer at this edge
//   push_data   - word to store
//   pop         - head word is consumed at this edge (head_valid & ready)
//   head_data   - registered head word
//   head_valid  - registered head valid
//   occ         - current occupancy (0..2)
// -----------------------------------------------------------------------------
module lifo_out_skid
    import lifo_pkg::*;
#(
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_valid,
    output logic [1:0]    occ
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    occ_q, occ_d;
    logic          valid_q, valid_d;

    // Next-state of the two storage slots and the occupancy count.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    tail_d = push_data;
                    occ_d  = 2'd2;
                end else begin
                    // Full: the controller never reads when full, so keep state.
                    occ_d = occ_q;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = (occ_q == 2'd0) ? 2'd0 : occ_q - 2'd1;
            end
            2'b11: begin
                // Head leaves; the new word lands behind whatever remains.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else begin
                    head_d = push_data;
                end
                occ_d = (occ_q == 2'd0) ? 2'd1 : occ_q;
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
        valid_d = (occ_d != 2'd0);
    end

    // Buffer state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= {DW{1'b0}};
            tail_q  <= {DW{1'b0}};
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign head_data  = head_q;
    assign head_valid = valid_q;
    assign occ        = occ_q;

endmodule

// File: rtl/lifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// lifo_drain_ctrl
// Reader-side controller for a small LIFO stack. On start it pops up to
// `count` entries (0 = until empty), captures each popped word one cycle
// after its read and streams the words downstream on valid/ready.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   start, count    - drain request and entry count (0 = drain until empty)
//   abort           - stop issuing reads; already-read words still delivered
//   lifo_read       - read pulse to the LIFO (combinational)
//   lifo_data       - LIFO data_out, valid the cycle after a read
//   lifo_empty      - LIFO empty flag
//   m_data, m_valid - downstream word and valid (registered)
//   m_ready         - downstream accept
//   busy            - high whenever not IDLE; upstream must not push
//   done            - one-cycle pulse when the drain has fully completed
//   popped          - reads issued in the last drain, held until next start
// -----------------------------------------------------------------------------
module lifo_drain_ctrl #(
    parameter int DATA_W = lifo_pkg::DATA_W,
    parameter int DEPTH  = lifo_pkg::DEPTH,
    parameter int CNT_W  = lifo_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic              abort,
    output logic              lifo_read,
    input  logic [DATA_W-1:0] lifo_data,
    input  logic              lifo_empty,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  popped
);

    import lifo_pkg::*;

    // The count width must be able to express every possible stack occupancy.
    if ((1 << CNT_W) <= DEPTH) begin : g_cnt_w_check
        $error("lifo_drain_ctrl: CNT_W too narrow for DEPTH");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] popped_q, popped_d;
    logic             unlimited_q, unlimited_d;
    logic             abort_lat_q, abort_lat_d;
    logic             rd_pending_q, rd_pending_d;

    logic             rd_s;
    logic             xfer_s;
    logic             flush_done_s;
    logic             load_s;
    logic [2:0]       inflight_s;
    logic [1:0]       occ_s;
    logic             skid_valid_s;
    logic [DATA_W-1:0] skid_data_s;

    lifo_out_skid #(
        .DW (DATA_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push       (rd_pending_q),
        .push_data  (lifo_data),
        .pop        (xfer_s),
        .head_data  (skid_data_s),
        .head_valid (skid_valid_s),
        .occ        (occ_s)
    );

    assign xfer_s = skid_valid_s & m_ready;

    // Words already committed to the buffer path after this cycle's transfer.
    // A transfer implies occ >= 1, so this never underflows.
    assign inflight_s = {1'b0, occ_s} + {2'b00, rd_pending_q} - {2'b00, xfer_s};

    assign flush_done_s = (state_q == FLUSH) & ~rd_pending_q & (occ_s == 2'd0);

    // A start is honoured in IDLE and also in the cycle that completes FLUSH,
    // since that cycle is the hand-back to IDLE and done is already visible.
    assign load_s = start & ((state_q == IDLE) | flush_done_s);

    // Read issue: only in DRAIN, never on an empty stack, never once aborting,
    // and only while fewer than two words would be held by pipe + buffer.
    always_comb begin
        rd_s = 1'b0;
        if ((state_q == DRAIN) && !reset && !lifo_empty && !abort_lat_q && !abort &&
            (unlimited_q || (remaining_q != {CNT_W{1'b0}})) && (inflight_s < 3'd2)) begin
            rd_s = 1'b1;
        end else begin
            rd_s = 1'b0;
        end
    end

    // Next-state, counters and abort latch.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        unlimited_d  = unlimited_q;
        popped_d     = popped_q;
        abort_lat_d  = abort_lat_q;
        rd_pending_d = rd_s;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (abort) begin
                    abort_lat_d = 1'b1;
                end else begin
                    abort_lat_d = abort_lat_q;
                end
                if (rd_s) begin
                    popped_d = popped_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (!unlimited_q) begin
                        remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        remaining_d = remaining_q;
                    end
                end else begin
                    popped_d = popped_q;
                end
                if ((!unlimited_q && (remaining_q == {CNT_W{1'b0}})) ||
                    (lifo_empty && !rd_s) || abort_lat_q) begin
                    state_d = FLUSH;
                end else begin
                    state_d = DRAIN;
                end
            end
            FLUSH: begin
                if (flush_done_s) begin
                    state_d = start ? DRAIN : IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_s) begin
            remaining_d = count;
            unlimited_d = (count == {CNT_W{1'b0}});
            popped_d    = {CNT_W{1'b0}};
            abort_lat_d = 1'b0;
        end else begin
            remaining_d = remaining_d;
        end
    end

    // Controller state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            remaining_q  <= {CNT_W{1'b0}};
            unlimited_q  <= 1'b0;
            popped_q     <= {CNT_W{1'b0}};
            abort_lat_q  <= 1'b0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            unlimited_q  <= unlimited_d;
            popped_q     <= popped_d;
            abort_lat_q  <= abort_lat_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    assign lifo_read = rd_s;
    assign m_data    = skid_data_s;
    assign m_valid   = skid_valid_s;
    assign busy      = (state_q != IDLE);
    assign done      = flush_done_s;
    assign popped    = popped_q;

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
module tb_lifo_drain_ctrl;

    localparam int DW  = 4;
    localparam int CW  = 3;
    localparam int DEP = 5;

    logic          clk = 1'b0;
    logic          reset, start, abort, m_ready;
    logic [CW-1:0] count;
    logic          lifo_read, lifo_empty, m_valid, busy, done;
    logic [DW-1:0] lifo_data, m_data;
    logic [CW-1:0] popped;

    always #5 clk = ~clk;

    lifo_drain_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .count      (count),
        .abort      (abort),
        .lifo_read  (lifo_read),
        .lifo_data  (lifo_data),
        .lifo_empty (lifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .popped     (popped)
    );

    // Behavioural LIFO: registered data_out, read+write together is a no-op.
    logic [DW-1:0] stk [DEP];
    int            stk_ptr = 0;
    logic [DW-1:0] stk_out;
    logic          lifo_wr, lifo_clr;
    logic [DW-1:0] lifo_wdata;

    assign lifo_data  = stk_out;
    assign lifo_empty = (stk_ptr == 0);

    always @(posedge clk) begin
        if (lifo_clr) begin
            stk_ptr <= 0;
        end else if (lifo_wr && !lifo_read) begin
            if (stk_ptr < DEP) begin
                stk[stk_ptr] <= lifo_wdata;
                stk_ptr      <= stk_ptr + 1;
            end
        end else if (lifo_read && !lifo_wr) begin
            if (stk_ptr > 0) begin
                stk_out <= stk[stk_ptr-1];
                stk_ptr <= stk_ptr - 1;
            end
        end
    end

    // Cycle counter and mid-cycle monitor.
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [DW-1:0] out_q[$];
    int   rd_cnt, rd_stall_cnt, viol_cnt, busy_cnt, busy_first, first_valid, done_cyc;
    logic done_seen;
    logic mon_clr;

    always @(negedge clk) begin
        if (mon_clr) begin
            out_q.delete();
            rd_cnt       <= 0;
            rd_stall_cnt <= 0;
            viol_cnt     <= 0;
            busy_cnt     <= 0;
            busy_first   <= -1;
            first_valid  <= -1;
            done_cyc     <= -1;
            done_seen    <= 1'b0;
        end else begin
            viol_cnt <= viol_cnt + int'(lifo_read && lifo_empty)
                                 + int'((rd_cnt - int'(out_q.size())) > 2);
            if (lifo_read) begin
                rd_cnt <= rd_cnt + 1;
                if (!m_ready) rd_stall_cnt <= rd_stall_cnt + 1;
            end
            if (m_valid && m_ready) out_q.push_back(m_data);
            if (m_valid && first_valid < 0) first_valid <= cyc_cnt;
            if (done && !done_seen) begin
                done_seen <= 1'b1;
                done_cyc  <= cyc_cnt;
            end
            if (busy) begin
                busy_cnt <= busy_cnt + 1;
                if (busy_first < 0) busy_first <= cyc_cnt;
            end
        end
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_pop;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        mon_clr  = 1'b1;
        lifo_clr = 1'b1;
        cyc();
        mon_clr  = 1'b0;
        lifo_clr = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        cyc();
        mon_clr = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] v);
        lifo_wr    = 1'b1;
        lifo_wdata = v;
        cyc();
        lifo_wr    = 1'b0;
    endtask

    // Reference model: a drain yields the top entries in pop order, limited by
    // the requested count (0 = all), the stack contents and any abort cut-off.
    function automatic void build_expected(input int cnt, input int max_reads);
        int take;
        exp_q.delete();
        take = (cnt == 0) ? stk_ptr : ((cnt < stk_ptr) ? cnt : stk_ptr);
        if (max_reads < take) take = max_reads;
        for (int i = 0; i < take; i++) exp_q.push_back(stk[stk_ptr-1-i]);
        exp_pop = CW'(take);
    endfunction

    function automatic bit seq_match();
        if (out_q.size() != exp_q.size()) return 1'b0;
        for (int i = 0; i < exp_q.size(); i++)
            if (out_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic start_drain(input int cnt, output int s);
        start = 1'b1;
        count = CW'(cnt);
        s     = cyc_cnt;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int k = 0;
        while (!done_seen && k < budget) begin
            cyc();
            k++;
        end
        ok = done_seen;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1; count = '0;
        lifo_wr = 1'b0; lifo_wdata = '0; lifo_clr = 1'b1; mon_clr = 1'b1;
        cyc();
        cyc();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (popped !== 3'd0) begin errors++; $display("FAIL reset_popped: got %0d expected 0", popped); end
        checks++; if (lifo_read !== 1'b0) begin errors++; $display("FAIL reset_lifo_read: got %b expected 0", lifo_read); end
        reset = 1'b0; lifo_clr = 1'b0; mon_clr = 1'b0;
        cyc();
    endtask

    task automatic test_drain_all(input string tag);
        int s; bit ok;
        clear_all();
        push(4'd3); push(4'd7); push(4'd9);
        m_ready = 1'b1;
        build_expected(0, 99);
        start_drain(0, s);
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s done_timeout: got no done expected done", tag); end
        checks++; if (first_valid != s + 3) begin errors++; $display("FAIL %s first_valid: got cycle %0d expected %0d", tag, first_valid, s + 3); end
        checks++; if (done_cyc != s + 6) begin errors++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_cyc, s + 6); end
        checks++; if (!seq_match()) begin errors++; $display("FAIL %s sequence: got %p expected %p", tag, out_q, exp_q); end
        checks++; if (popped !== exp_pop) begin errors++; $display("FAIL %s popped: got %0d expected %0d", tag, popped, exp_pop); end
        checks++; if (stk_ptr != 0) begin errors++; $display("FAIL %s lifo_left: got %0d expected 0", tag, stk_ptr); end
        checks++; if (viol_cnt != 0) begin errors++; $display("FAIL %s protocol: got %0d violations expected 0", tag, viol_cnt); end
        cyc();
    endtask

    task automatic test_limited();
        int s; bit ok;
        clear_all();
        for (int v = 1; v <= 5; v++) push(DW'(v));
        build_expected(2, 99);
        start_drain(2, s);
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL limited done_timeout: got no done expected done"); end
        checks++; if (!seq_match()) begin errors++; $display("FAIL limited sequence: got %p expected %p", out_q, exp_q); end
        checks++; if (popped !== exp_pop) begin errors++; $display("FAIL limited popped: got %0d expected %0d", popped, exp_pop); end
        checks++; if (stk_ptr != 3) begin errors++; $display("FAIL limited lifo_left: got %0d expected 3", stk_ptr); end
        checks++; if (lifo_empty !== 1'b0) begin errors++; $display("FAIL limited lifo_empty: got %b expected 0", lifo_empty); end
        cyc();
    endtask

    task automatic test_backpressure();
        int s; bit ok;
        clear_all();
        push(4'd3); push(4'd7); push(4'd9);
        m_ready = 1'b0;
        build_expected(0, 99);
        start_drain(0, s);
        repeat (5) cyc();
        m_ready = 1'b1;
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall done_timeout: got no done expected done"); end
        checks++; if (rd_stall_cnt != 2) begin errors++; $display("FAIL stall reads: got %0d expected 2", rd_stall_cnt); end
        checks++; if (!seq_match()) begin errors++; $display("FAIL stall sequence: got %p expected %p", out_q, exp_q); end
        checks++; if (popped !== exp_pop) begin errors++; $display("FAIL stall popped: got %0d expected %0d", popped, exp_pop); end
        checks++; if (viol_cnt != 0) begin errors++; $display("FAIL stall protocol: got %0d violations expected 0", viol_cnt); end
        cyc();
    endtask

    task automatic test_empty_start();
        int s; bit ok;
        clear_all();
        start_drain(4, s);
        wait_done(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL empty done_timeout: got no done expected done"); end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL empty reads: got %0d expected 0", rd_cnt); end
        checks++; if (done_cyc != s + 2) begin errors++; $display("FAIL empty done_cycle: got %0d expected %0d", done_cyc, s + 2); end
        checks++; if (popped !== 3'd0) begin errors++; $display("FAIL empty popped: got %0d expected 0", popped); end
        checks++; if (busy_first != s + 1) begin errors++; $display("FAIL empty busy_first: got %0d expected %0d", busy_first, s + 1); end
        checks++; if (busy_cnt != 2) begin errors++; $display("FAIL empty busy_cycles: got %0d expected 2", busy_cnt); end
        cyc();
    endtask

    task automatic test_abort();
        int s; bit ok;
        clear_all();
        for (int v = 1; v <= 5; v++) push(DW'(v));
        build_expected(0, 1);
        start_drain(0, s);
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort done_timeout: got no done expected done"); end
        checks++; if (!seq_match()) begin errors++; $display("FAIL abort sequence: got %p expected %p", out_q, exp_q); end
        checks++; if (popped !== exp_pop) begin errors++; $display("FAIL abort popped: got %0d expected %0d", popped, exp_pop); end
        checks++; if (stk_ptr != 4) begin errors++; $display("FAIL abort lifo_left: got %0d expected 4", stk_ptr); end
        cyc();
    endtask

    task automatic test_reset_mid();
        int s;
        clear_all();
        push(4'd3); push(4'd7); push(4'd9);
        start_drain(0, s);
        cyc();
        reset = 1'b1;
        cyc();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midreset_m_valid: got %b expected 0", m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
        checks++; if (popped !== 3'd0) begin errors++; $display("FAIL midreset_popped: got %0d expected 0", popped); end
        reset = 1'b0;
        cyc();
        test_drain_all("after_reset");
    endtask

    task automatic test_back_to_back();
        int s; bit ok;
        clear_all();
        for (int v = 1; v <= 5; v++) push(DW'(v));
        build_expected(2, 99);
        start_drain(2, s);
        wait_done(60, ok);
        checks++; if (!ok || !seq_match() || popped !== exp_pop) begin errors++; $display("FAIL b2b_first: got %p popped %0d expected %p popped %0d", out_q, popped, exp_q, exp_pop); end
        clear_mon();
        build_expected(0, 99);
        start_drain(0, s);
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_second done_timeout: got no done expected done"); end
        checks++; if (!seq_match()) begin errors++; $display("FAIL b2b_second sequence: got %p expected %p", out_q, exp_q); end
        checks++; if (popped !== exp_pop) begin errors++; $display("FAIL b2b_second popped: got %0d expected %0d", popped, exp_pop); end
        checks++; if (stk_ptr != 0) begin errors++; $display("FAIL b2b_second lifo_left: got %0d expected 0", stk_ptr); end
        cyc();
    endtask

    task automatic test_random();
        int s, n, cnt, k, left;
        for (int it = 0; it < 30; it++) begin
            clear_all();
            n = $urandom_range(0, DEP);
            for (int i = 0; i < n; i++) push(DW'($urandom_range(0, 15)));
            cnt = $urandom_range(0, 7);
            build_expected(cnt, 99);
            left = n - exp_q.size();
            start_drain(cnt, s);
            k = 0;
            while (!done_seen && k < 200) begin
                m_ready = ($urandom_range(0, 3) != 0);
                cyc();
                k++;
            end
            m_ready = 1'b1;
            checks++; if (!done_seen) begin errors++; $display("FAIL rand%0d done_timeout: got no done expected done", it); end
            checks++; if (!seq_match()) begin errors++; $display("FAIL rand%0d sequence: got %p expected %p", it, out_q, exp_q); end
            checks++; if (popped !== exp_pop) begin errors++; $display("FAIL rand%0d popped: got %0d expected %0d", it, popped, exp_pop); end
            checks++; if (stk_ptr != left) begin errors++; $display("FAIL rand%0d lifo_left: got %0d expected %0d", it, stk_ptr, left); end
            checks++; if (viol_cnt != 0) begin errors++; $display("FAIL rand%0d protocol: got %0d violations expected 0", it, viol_cnt); end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_drain_all("drain_all");
        test_limited();
        test_backpressure();
        test_empty_start();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
